// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter: arbitrates NREQ writers onto one shared latch data bus.
// Each write goes SETUP -> PULSE (EN_CYCLES) -> HOLD, so a latch word opens only on stable data.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req[NREQ]           write requests, held until ack
//   req_addr[NREQ*AW]   word address per requester, slice i = [i*AW +: AW]
//   req_data[NREQ*DW]   write data per requester, slice i = [i*DW +: DW]
//   ack[NREQ]           one-cycle one-hot write-complete pulse (HOLD)
//   busy                high in SETUP, PULSE and HOLD
//   lat_d[DW]           shared data bus to all latch words
//   lat_en[2**AW]       one-hot gate enables, one per latch word
// Build option: define LATCH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module latch_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int EN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [DW-1:0]        lat_d,
    output logic [(2**AW)-1:0]   lat_en
);
    localparam int NW = 2**AW;
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d, base, idx, sel;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   lat_d_q, lat_d_d;
    logic [NW-1:0]   lat_en_q, lat_en_d;
    logic            found, grant, last;

`ifdef LATCH_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;
    assign base = ptr_q;
    always_comb ptr_d = (state_q == HOLD) ? IW'((int'(gnt_q) + 1) % NREQ) : ptr_q;
    always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
`endif

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        // first requesting index at or above base, wrapping modulo NREQ
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(base) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        grant    = (state_q == IDLE) && found;
        last     = cnt_q == 4'(EN_CYCLES - 1);
        gnt_d    = grant ? sel : gnt_q;
        addr_d   = grant ? req_addr[int'(sel)*AW +: AW] : addr_q;
        lat_d_d  = grant ? req_data[int'(sel)*DW +: DW] : lat_d_q;
        cnt_d    = (state_q == PULSE && !last) ? cnt_q + 4'd1 : '0;
        state_d  = state_q == IDLE  ? (found ? SETUP : IDLE) :
                   state_q == SETUP ? PULSE :
                   state_q == PULSE ? (last ? HOLD : PULSE) : IDLE;
        // outputs are registered from the state being entered
        busy_d   = state_d != IDLE;
        lat_en_d = (state_d == PULSE) ? NW'(1) << addr_q : '0;
        ack_d    = (state_d == HOLD) ? NREQ'(1) << gnt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
        end
    end

    assign ack    = ack_q;
    assign busy   = busy_q;
    assign lat_d  = lat_d_q;
    assign lat_en = lat_en_q;
endmodule
